// File: rtl/water_level_encoder.sv
// water_level_encoder: synchronise, debounce and validate three float switches into a 2-bit level code
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   sensor_low    raw float switch at low mark, 1 = wet
//   sensor_mid    raw float switch at mid mark, 1 = wet
//   sensor_high   raw float switch at high mark, 1 = wet
//   data          committed level code: 00 critical, 01 low, 10 mid, 11 high
//   data_valid    1 once a valid pattern has been committed since reset
//   level_changed one-cycle pulse when data takes a new value (or on the first commit)
//   sensor_fault  1 while the last stable pattern is physically impossible
module water_level_encoder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_low,
  input  logic       sensor_mid,
  input  logic       sensor_high,
  output logic [1:0] data,
  output logic       data_valid,
  output logic       level_changed,
  output logic       sensor_fault
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {SETTLE, STABLE} state_t;
  state_t                      state_q;
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [SYNC_STAGES-1:0]      vld_q;
  logic                        loaded_q;
  logic [2:0]                  cand_q;
  logic [CW-1:0]               cnt_q;
  logic [1:0]                  data_q;
  logic                        valid_q;
  logic                        changed_q;
  logic                        fault_q;
  logic [2:0]                  p;
  logic                        p_ok;
  logic [1:0]                  p_code;
  logic                        new_p;
  assign p      = sync_q[SYNC_STAGES-1];
  assign p_ok   = p == 3'b000 || p == 3'b001 || p == 3'b011 || p == 3'b111;
  assign p_code = p[2] ? 2'd3 : p[1] ? 2'd2 : {1'b0, p[0]};
  // The first trusted pattern after reset is always treated as new, so the
  // debounce window starts only once the synchroniser has been refilled.
  assign new_p  = !loaded_q || p != cand_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      vld_q     <= '0;
      loaded_q  <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      state_q   <= SETTLE;
      data_q    <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], sensor_high, sensor_mid, sensor_low};
      vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      changed_q <= 1'b0;
      if (vld_q[SYNC_STAGES-1]) begin
        if (new_p) begin
          cand_q   <= p;
          cnt_q    <= '0;
          state_q  <= SETTLE;
          loaded_q <= 1'b1;
        end else if (state_q == SETTLE) begin
          if (cnt_q == LAST) begin
            state_q <= STABLE;
            if (p_ok) begin
              data_q    <= p_code;
              valid_q   <= 1'b1;
              fault_q   <= 1'b0;
              changed_q <= !valid_q || p_code != data_q;
            end else begin
              fault_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end
  end
  assign data          = data_q;
  assign data_valid    = valid_q;
  assign level_changed = changed_q;
  assign sensor_fault  = fault_q;
endmodule

// File: tb/tb_water_level_encoder.sv
// tb_water_level_encoder: directed and random checks of water_level_encoder against a run-length reference model
module tb_water_level_encoder;
  localparam int S = 2;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_low, sensor_mid, sensor_high;
  logic [1:0] data;
  logic       data_valid, level_changed, sensor_fault;
  water_level_encoder #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_low(sensor_low), .sensor_mid(sensor_mid),
    .sensor_high(sensor_high), .data(data), .data_valid(data_valid),
    .level_changed(level_changed), .sensor_fault(sensor_fault)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, pulses = 0, last_pulse = -1, fault_edge = -1, mark = 0;
  int edge_cnt;
  logic [1:0] exp_data;
  logic exp_valid, exp_lc, exp_fault;
  logic [2:0] samp[$];
  int runs[$];
  // Reference: a pattern commits when its run of identical raw samples (counted
  // since reset) reaches exactly D+1, S edges after the last sample of that run.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp.delete();
      runs.delete();
      edge_cnt  <= 0;
      exp_data  <= '0;
      exp_valid <= 1'b0;
      exp_lc    <= 1'b0;
      exp_fault <= 1'b0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      runs.push_back((samp.size() > 0 && samp[$] == {sensor_high, sensor_mid, sensor_low}) ? runs[$] + 1 : 1);
      samp.push_back({sensor_high, sensor_mid, sensor_low});
      exp_lc <= 1'b0;
      if (samp.size() > S && runs[samp.size()-1-S] == D + 1) begin
        if ((samp[samp.size()-1-S] & (samp[samp.size()-1-S] + 3'd1)) == 3'd0) begin
          exp_lc    <= !exp_valid || int'(exp_data) != $countones(samp[samp.size()-1-S]);
          exp_data  <= 2'($countones(samp[samp.size()-1-S]));
          exp_valid <= 1'b1;
          exp_fault <= 1'b0;
        end else begin
          exp_fault <= 1'b1;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("data", 32'(data), 32'(exp_data));
    chk("data_valid", 32'(data_valid), 32'(exp_valid));
    chk("level_changed", 32'(level_changed), 32'(exp_lc));
    chk("sensor_fault", 32'(sensor_fault), 32'(exp_fault));
    if (level_changed === 1'b1) begin
      pulses++;
      last_pulse = edge_cnt;
    end
    if (sensor_fault === 1'b1 && fault_edge < 0) fault_edge = edge_cnt;
  endtask
  task automatic drive(input logic [2:0] pat, input int n);
    {sensor_high, sensor_mid, sensor_low} = pat;
    mark = edge_cnt;
    repeat (n) cyc();
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_valid"}, 32'(data_valid), 0);
    chk({tag, "_changed"}, 32'(level_changed), 0);
    chk({tag, "_fault"}, 32'(sensor_fault), 0);
  endtask
  int p0;
  logic [2:0] pat;
  logic [2:0] steps[3] = '{3'b001, 3'b011, 3'b111};
  initial begin
    rst_n = 1'b0;
    {sensor_high, sensor_mid, sensor_low} = 3'b000;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b000, 10);
    chk("s1_pulses", pulses, 1);
    chk("s1_edge", last_pulse, 7);
    chk("s1_valid", 32'(data_valid), 1);
    chk("s1_data", 32'(data), 0);
    for (int i = 0; i < 3; i++) begin
      p0 = pulses;
      drive(steps[i], 10);
      chk("s2_pulses", pulses, p0 + 1);
      chk("s2_edge", last_pulse, mark + 7);
      chk("s2_data", 32'(data), i + 1);
      chk("s2_fault", 32'(sensor_fault), 0);
    end
    drive(3'b001, 10);
    p0 = pulses;
    drive(3'b011, 2);
    drive(3'b001, 10);
    chk("s3_pulses", pulses, p0);
    chk("s3_data", 32'(data), 1);
    chk("s3_fault", 32'(sensor_fault), 0);
    drive(3'b011, 10);
    fault_edge = -1;
    p0 = pulses;
    drive(3'b101, 10);
    chk("s4_fault_edge", fault_edge, mark + 7);
    chk("s4_fault", 32'(sensor_fault), 1);
    chk("s4_data", 32'(data), 2);
    chk("s4_pulses", pulses, p0);
    drive(3'b111, 10);
    chk("s4_clear", 32'(sensor_fault), 0);
    chk("s4_data_hi", 32'(data), 3);
    chk("s4_pulse_hi", pulses, p0 + 1);
    drive(3'b001, 10);
    {sensor_high, sensor_mid, sensor_low} = 3'b011;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1 chk_zero("s5_async");
    cyc();
    rst_n = 1'b1;
    p0 = pulses;
    drive(3'b011, 10);
    chk("s5_edge", last_pulse, 7);
    chk("s5_pulses", pulses, p0 + 1);
    chk("s5_data", 32'(data), 2);
    p0 = pulses;
    pat = 3'b011;
    for (int i = 0; i < 33; i++) begin
      pat[0] = ~pat[0];
      drive(pat, 3);
    end
    chk("s6_pulses", pulses, p0);
    chk("s6_data", 32'(data), 2);
    chk("s6_fault", 32'(sensor_fault), 0);
    for (int i = 0; i < 80; i++) drive(3'($urandom_range(0, 7)), int'($urandom_range(1, 9)));
    drive(3'b111, 10);
    chk("rand_final", 32'(data), 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
